muldiv_unit: RTL

Iterative multi-cycle multiply/divide unit for the CPU datapath. It takes two operands read from the register file read ports (`q_a`, `q_b`) together with a destination address. It computes an unsigned product (low or high half), quotient or remainder one bit per cycle. It then drives the register file write port (`data_c`, `addr_c`, `we`) for exactly one cycle, so it sits directly downstream of the register read ports and upstream of the register write port.

---
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ==== muldiv_unit : iterative unsigned multiply/divide, one result bit per cycle (rev 1.0) ====
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module muldiv_unit #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [ADDR_WIDTH-1:0] dst,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_c,
  output logic [ADDR_WIDTH-1:0] addr_c,
  output logic                  we
);

  localparam int                c_CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(DATA_WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [1:0]              r_op;
  logic [ADDR_WIDTH-1:0]   r_dst;
  // {r_acc, r_q}: product register for multiply, {remainder, dividend/quotient} for divide
  logic [DATA_WIDTH-1:0]   r_acc;
  logic [DATA_WIDTH-1:0]   r_q;
  logic [DATA_WIDTH-1:0]   r_b;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [ADDR_WIDTH-1:0]   r_addr;

  logic                    w_last;
  logic [DATA_WIDTH:0]     w_sum;
  logic [DATA_WIDTH:0]     w_shift;
  logic [DATA_WIDTH-1:0]   w_diff;
  logic                    w_ge;
  logic [DATA_WIDTH-1:0]   w_acc_nxt;
  logic [DATA_WIDTH-1:0]   w_q_nxt;
  logic [DATA_WIDTH-1:0]   w_result;

  assign w_last  = (r_cnt == c_CNT_ONE);
  assign w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(DATA_WIDTH+1){1'b0}});
  assign w_shift = {r_acc, r_q[DATA_WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  // Only used when w_ge holds, so the true difference always fits in DATA_WIDTH bits
  assign w_diff  = w_shift[DATA_WIDTH-1:0] - r_b;

  always_comb begin
    w_acc_nxt = r_acc;
    w_q_nxt   = r_q;
    if (r_op[1]) begin
      if (w_ge) begin
        w_acc_nxt = w_diff;
        w_q_nxt   = {r_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_shift[DATA_WIDTH-1:0];
        w_q_nxt   = {r_q[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = w_sum[DATA_WIDTH:1];
      w_q_nxt   = {w_sum[0], r_q[DATA_WIDTH-1:1]};
    end
  end

  // MULL/DIVQ come from the low/quotient half, MULH/DIVR from the high/remainder half
  assign w_result = r_op[0] ? w_acc_nxt : w_q_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_dst  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_b    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_we   <= 1'b0;
      r_data <= '0;
      r_addr <= '0;
    end else begin
      r_done <= 1'b0;
      r_we   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_dst  <= dst;
            r_q    <= src_a;
            r_b    <= src_b;
            r_acc  <= '0;
            r_cnt  <= c_CNT_INIT;
            r_busy <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - c_CNT_ONE;
          if (w_last) begin
            r_done <= 1'b1;
            r_we   <= (r_dst != '0);
            r_data <= w_result;
            r_addr <= r_dst;
          end
        end
        S_WB:    r_busy <= 1'b0;
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign we     = r_we;
  assign data_c = r_data;
  assign addr_c = r_addr;

endmodule

`default_nettype wire
